// File: rtl/time_set_sequencer_if.sv
// Key/tick inputs and status/increment/display outputs of the time-set sequencer.
interface time_set_sequencer_if;
  logic       tick_10ms;
  logic       tick_1s;
  logic       mode_pulse;
  logic       add_pulse;
  logic       add_held;
  logic [2:0] status;
  logic       inc_hour;
  logic       inc_minute;
  logic       inc_month;
  logic       inc_day;
  logic       run_enable;
  logic       sec_clear;
  logic [3:0] digit_mask;

  modport master (
    output tick_10ms, tick_1s, mode_pulse, add_pulse, add_held,
    input  status, inc_hour, inc_minute, inc_month, inc_day,
           run_enable, sec_clear, digit_mask
  );

  modport slave (
    input  tick_10ms, tick_1s, mode_pulse, add_pulse, add_held,
    output status, inc_hour, inc_minute, inc_month, inc_day,
           run_enable, sec_clear, digit_mask
  );
endinterface

// File: rtl/time_set_sequencer.sv
// Clock set-mode sequencer: mode stepping, key auto-repeat, idle timeout, blink and seconds hold.
// All outputs registered, one cycle after the sampled input event; no backpressure.
module time_set_sequencer #(
  parameter int TIMEOUT_S    = 30,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int BLINK_HALF   = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  time_set_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    SET_HOUR   = 3'd1,
    SET_MINUTE = 3'd2,
    SET_MONTH  = 3'd3,
    SET_DAY    = 3'd4
  } status_e;

  localparam logic [5:0] TIMEOUT_W = 6'(TIMEOUT_S);
  localparam logic [6:0] DELAY_W   = 7'(REPEAT_DELAY);
  localparam logic [6:0] RATE_W    = 7'(REPEAT_RATE);
  localparam logic [6:0] BLINK_W   = 7'(BLINK_HALF);

  status_e    status_q, status_d;
  logic [5:0] idle_q, idle_d;
  logic [6:0] rep_q, rep_d;
  logic       rpt_q, rpt_d;
  logic [6:0] blink_q, blink_d;
  logic       phase_q, phase_d;
  logic       edited_q, edited_d;
  logic       run_enable_q, run_enable_d;
  logic       sec_clear_q, sec_clear_d;
  logic [3:0] inc_q, inc_d;
  logic [3:0] mask_q, mask_d;

  logic       in_set, key_evt, timeout, status_chg, rep_fire, inc_fire;
  logic [6:0] rep_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q     <= SHOW_TIME;
      idle_q       <= '0;
      rep_q        <= '0;
      rpt_q        <= 1'b0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      edited_q     <= 1'b0;
      run_enable_q <= 1'b1;
      sec_clear_q  <= 1'b0;
      inc_q        <= '0;
      mask_q       <= 4'b1111;
    end else begin
      status_q     <= status_d;
      idle_q       <= idle_d;
      rep_q        <= rep_d;
      rpt_q        <= rpt_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      edited_q     <= edited_d;
      run_enable_q <= run_enable_d;
      sec_clear_q  <= sec_clear_d;
      inc_q        <= inc_d;
      mask_q       <= mask_d;
    end
  end

  always_comb begin
    status_d     = status_q;
    idle_d       = idle_q;
    rep_d        = rep_q;
    rpt_d        = rpt_q;
    blink_d      = blink_q;
    phase_d      = phase_q;
    edited_d     = edited_q;
    run_enable_d = run_enable_q;
    sec_clear_d  = 1'b0;
    inc_d        = '0;
    mask_d       = 4'b1111;
    rep_fire     = 1'b0;
    rep_next     = rep_q + 7'd1;

    in_set  = (status_q != SHOW_TIME);
    key_evt = bus.mode_pulse | bus.add_pulse | bus.add_held;
    // Any key activity in the expiring cycle keeps the user in set mode.
    timeout = in_set && bus.tick_1s && !key_evt && ((idle_q + 6'd1) == TIMEOUT_W);

    if (bus.mode_pulse) begin
      case (status_q)
        SHOW_TIME:  status_d = SET_HOUR;
        SET_HOUR:   status_d = SET_MINUTE;
        SET_MINUTE: status_d = SET_MONTH;
        SET_MONTH:  status_d = SET_DAY;
        default:    status_d = SHOW_TIME;
      endcase
    end else if (timeout) begin
      status_d = SHOW_TIME;
    end
    status_chg = bus.mode_pulse | timeout;

    if (!in_set || key_evt || timeout) idle_d = '0;
    else if (bus.tick_1s)              idle_d = idle_q + 6'd1;

    // First repeat after DELAY ticks, then every RATE ticks while held.
    if (!in_set || !bus.add_held || status_chg) begin
      rep_d = '0;
      rpt_d = 1'b0;
    end else if (bus.tick_10ms) begin
      if (rep_next == (rpt_q ? RATE_W : DELAY_W)) begin
        rep_fire = 1'b1;
        rep_d    = '0;
        rpt_d    = 1'b1;
      end else begin
        rep_d = rep_next;
      end
    end

    inc_fire = in_set && !bus.mode_pulse && (bus.add_pulse || rep_fire);
    inc_d    = {inc_fire && status_q == SET_HOUR,  inc_fire && status_q == SET_MINUTE,
                inc_fire && status_q == SET_MONTH, inc_fire && status_q == SET_DAY};

    // Seconds stay frozen from the first edit until the clear pulse on return to SHOW_TIME.
    sec_clear_d = in_set && (status_d == SHOW_TIME) && edited_q;
    if (sec_clear_q)   edited_d = 1'b0;
    if (inc_fire)      edited_d = 1'b1;
    if (sec_clear_q)   run_enable_d = 1'b1;
    else if (edited_q) run_enable_d = 1'b0;

    if (!in_set || status_chg || bus.add_held) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (bus.tick_10ms) begin
      if ((blink_q + 7'd1) == BLINK_W) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 7'd1;
      end
    end

    case (status_d)
      SET_HOUR, SET_MONTH:  mask_d = 4'b1100;
      SET_MINUTE, SET_DAY:  mask_d = 4'b0011;
      default:              mask_d = 4'b1111;
    endcase
    if (phase_d) mask_d = 4'b0000;
  end

  assign bus.status     = status_q;
  assign bus.inc_hour   = inc_q[3];
  assign bus.inc_minute = inc_q[2];
  assign bus.inc_month  = inc_q[1];
  assign bus.inc_day    = inc_q[0];
  assign bus.run_enable = run_enable_q;
  assign bus.sec_clear  = sec_clear_q;
  assign bus.digit_mask = mask_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer; increments are scoreboarded with their expected cycle.
module tb_time_set_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  time_set_sequencer_if bus ();

  time_set_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] C_HOUR = 4'b1000;
  localparam logic [3:0] C_MIN  = 4'b0100;
  localparam logic [3:0] C_DAY  = 4'b0001;

  wire [3:0] inc_vec = {bus.inc_hour, bus.inc_minute, bus.inc_month, bus.inc_day};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [3:0] mk,
                         input logic run, input logic sc);
    check({tag, "_status"}, 32'(bus.status), 32'(st));
    check({tag, "_mask"},   32'(bus.digit_mask), 32'(mk));
    check({tag, "_run"},    32'(bus.run_enable), 32'(run));
    check({tag, "_secclr"}, 32'(bus.sec_clear), 32'(sc));
  endtask

  task automatic expect_inc(input logic [3:0] code);
    sb.push_back('{code: code, at: cyc + 1});
  endtask

  task automatic step(input logic m, input logic a, input logic h, input logic t10, input logic t1);
    bus.mode_pulse = m;
    bus.add_pulse  = a;
    bus.add_held   = h;
    bus.tick_10ms  = t10;
    bus.tick_1s    = t1;
    @(posedge clock);
    #1;
    bus.mode_pulse = 1'b0;
    bus.add_pulse  = 1'b0;
    bus.tick_10ms  = 1'b0;
    bus.tick_1s    = 1'b0;
  endtask

  task automatic mode_n(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Increment monitor: every inc pulse must match the oldest expected entry and its cycle.
  always @(negedge clock) begin
    exp_t e;
    if (inc_vec != 4'b0000) begin
      if (sb.size() == 0) begin
        check("inc_spurious", 32'(inc_vec), 32'd0);
      end else begin
        e = sb.pop_front();
        check("inc_code", 32'(inc_vec), 32'(e.code));
        check("inc_cycle", cyc, e.at);
      end
    end else if (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check("inc_missing", 32'(inc_vec), 32'(e.code));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] est;
    bus.mode_pulse = 1'b0;
    bus.add_pulse  = 1'b0;
    bus.add_held   = 1'b0;
    bus.tick_10ms  = 1'b0;
    bus.tick_1s    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_out("reset", 3'd0, 4'b1111, 1'b1, 1'b0);
    check("reset_inc", 32'(inc_vec), 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mode cycling from reset
    for (int i = 1; i <= 5; i++) begin
      mode_n(1);
      est = 3'(i % 5);
      chk_out("mode_cycle", est, (est == 3'd0) ? 4'b1111 : (est[0] ? 4'b1100 : 4'b0011), 1'b1, 1'b0);
    end

    // Blink phase in SET_HOUR, reset by mode change
    mode_n(1);
    repeat (24) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_pre", 32'(bus.digit_mask), 32'(4'b1100));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_off", 32'(bus.digit_mask), 32'(4'b0000));
    repeat (24) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_off_hold", 32'(bus.digit_mask), 32'(4'b0000));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_on", 32'(bus.digit_mask), 32'(4'b1100));
    repeat (25) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mode_n(1);
    chk_out("blink_modechg", 3'd2, 4'b0011, 1'b1, 1'b0);

    // Auto-repeat in SET_MINUTE: incs at ticks 50,60,...,100
    for (int t = 1; t <= 100; t++) begin
      if (t >= 50 && (t - 50) % 10 == 0) expect_inc(C_MIN);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (t == 50) check("rep_run_incycle", 32'(bus.run_enable), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (t == 50) check("rep_run_after", 32'(bus.run_enable), 32'd0);
    end
    chk_out("rep_end", 3'd2, 4'b0011, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mode_n(2);
    chk_out("edit_day", 3'd4, 4'b0011, 1'b0, 1'b0);
    mode_n(1);
    chk_out("wrap_exit", 3'd0, 4'b1111, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("wrap_exit_next", 3'd0, 4'b1111, 1'b1, 1'b0);

    // Mode and add coincident in SET_MONTH: mode wins
    mode_n(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("mode_wins", 3'd4, 4'b0011, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Add on the 30th idle second cancels the timeout and restarts idle count
    repeat (29) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("idle29_status", 32'(bus.status), 32'd4);
    expect_inc(C_DAY);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("cancel_status", 32'(bus.status), 32'd4);
    repeat (29) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("idle_restart", 3'd4, 4'b0011, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("timeout_day", 3'd0, 4'b1111, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("timeout_day_next", 3'd0, 4'b1111, 1'b1, 1'b0);

    // One edit in SET_HOUR then 30 s idle
    mode_n(1);
    expect_inc(C_HOUR);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (29) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("hour_idle29", 3'd1, 4'b1100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("hour_timeout", 3'd0, 4'b1111, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("hour_timeout_next", 3'd0, 4'b1111, 1'b1, 1'b0);

    // Exits without edits leave the seconds chain alone
    mode_n(5);
    chk_out("noedit_wrap", 3'd0, 4'b1111, 1'b1, 1'b0);
    mode_n(1);
    repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("noedit_timeout", 3'd0, 4'b1111, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a held-add repeat
    mode_n(2);
    for (int t = 1; t <= 55; t++) begin
      if (t == 50) expect_inc(C_MIN);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk_out("pre_reset", 3'd2, 4'b0011, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_out("mid_reset", 3'd0, 4'b1111, 1'b1, 1'b0);
    check("mid_reset_inc", 32'(inc_vec), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (60) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_out("post_reset", 3'd0, 4'b1111, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/time_set_sequencer.md
TIME_SET_SEQUENCER -- requirements
Module: time_set_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 30, set-mode idle timeout in tick_1s units (1..63).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50, key-hold delay before auto-repeat in tick_10ms units (1..127).
REQ-003 SHALL have parameter REPEAT_RATE, default 10, auto-repeat period in tick_10ms units (1..127).
REQ-004 SHALL have parameter BLINK_HALF, default 25, blink half-period in tick_10ms units (1..127).
REQ-005 SHALL have port: clock  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: tick_10ms  input  1  one-cycle 10 ms strobe.
REQ-008 SHALL have port: tick_1s  input  1  one-cycle 1 s strobe.
REQ-009 SHALL have port: mode_pulse  input  1  debounced mode-key event, one cycle.
REQ-010 SHALL have port: add_pulse  input  1  debounced add-key event, one cycle.
REQ-011 SHALL have port: add_held  input  1  debounced add-key level, 1 = pressed.
REQ-012 SHALL have port: status  output  3  0 SHOW_TIME, 1 SET_HOUR, 2 SET_MINUTE, 3 SET_MONTH, 4 SET_DAY.
REQ-013 SHALL have port: inc_hour / inc_minute / inc_month / inc_day  output  1 each  one-cycle increment requests to the time counters.
REQ-014 SHALL have port: run_enable  output  1  seconds chain enable.
REQ-015 SHALL have port: sec_clear  output  1  one-cycle seconds/prescaler clear.
REQ-016 SHALL have port: digit_mask  output  4  per-digit display enable, bit3 = leftmost.

Function
REQ-017 SHALL advance status 0->1->2->3->4->0 on each mode_pulse; values 5..7 never occur.
REQ-018 SHALL, in a SET state, assert exactly the inc_* output matching status for one cycle, the cycle after add_pulse; no inc_* in SHOW_TIME.
REQ-019 SHALL ignore add_pulse when mode_pulse is asserted in the same cycle (mode wins).
REQ-020 SHALL count tick_10ms while add_held=1 in a SET state; on count reaching REPEAT_DELAY issue one inc, then one inc every further REPEAT_RATE ticks.
REQ-021 SHALL clear the repeat counter when add_held=0, on any status change, or in SHOW_TIME.
REQ-022 SHALL never issue more than one inc_* per cycle; repeat and add_pulse coincident yield one inc.
REQ-023 SHALL count tick_1s in a SET state as idle time; cleared by mode_pulse, add_pulse, or add_held=1.
REQ-024 SHALL return status to SHOW_TIME when idle count reaches TIMEOUT_S; a key event in that same cycle cancels the timeout.
REQ-025 SHALL set an edited flag on the first inc_* in a SET state and drive run_enable=0 from the following cycle.
REQ-026 SHALL, on entry to SHOW_TIME (mode wrap or timeout) with edited=1, pulse sec_clear one cycle, then set run_enable=1 and clear edited the following cycle.
REQ-027 SHALL keep run_enable=1 and no sec_clear on exit without edits.
REQ-028 SHALL toggle a blink phase every BLINK_HALF tick_10ms in SET states; phase reset to 0 (visible) on every status change and while add_held=1.
REQ-029 SHALL drive digit_mask: SHOW_TIME 1111; SET_HOUR/SET_MONTH 1100; SET_MINUTE/SET_DAY 0011; forced to 0000 when phase=1.
REQ-030 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-031 SHALL on reset=0 immediately force status=0, all inc_*=0, sec_clear=0, run_enable=1, digit_mask=1111, edited=0, phase=0, all counters 0.
REQ-032 SHALL abandon any in-progress repeat, timeout or exit sequence when reset asserts mid-operation; first post-release cycle behaves as fresh SHOW_TIME.

Verification
REQ-033 SHALL cover: 5 mode_pulse from reset -> status 1,2,3,4,0; digit_mask 1100,0011,1100,0011,1111 (phase 0).
REQ-034 SHALL cover: status=2, add_held high 100 tick_10ms with defaults -> inc_minute at ticks 50,60,70,80,90,100 (6 pulses), run_enable=0 after first.
REQ-035 SHALL cover: status=1, one add_pulse then 30 tick_1s idle -> status=0, sec_clear one cycle, run_enable=1 next cycle.
REQ-036 SHALL cover: mode_pulse and add_pulse same cycle in status=3 -> status=4, no inc_* asserted.
REQ-037 SHALL cover: status=4, 29 tick_1s then add_pulse coincident with 30th -> status stays 4, inc_day pulses, idle count 0.
REQ-038 SHALL cover: reset asserted at tick 55 of held add in status=2 -> all outputs reset values same cycle; no inc after release.
